// File: rtl/gameport_pkg.sv
// Shared constants and position mapping for the PC game-port emulator.
package gameport_pkg;

    localparam int unsigned JD_W = 8;
    localparam int unsigned JA_W = 16;
    localparam int unsigned POS_W = 8;

    localparam int unsigned JD_UP    = 0;
    localparam int unsigned JD_DOWN  = 1;
    localparam int unsigned JD_LEFT  = 2;
    localparam int unsigned JD_RIGHT = 3;
    localparam int unsigned JD_FIRE1 = 4;
    localparam int unsigned JD_FIRE2 = 5;

    localparam int unsigned DO_AX   = 0;
    localparam int unsigned DO_AY   = 1;
    localparam int unsigned DO_BX   = 2;
    localparam int unsigned DO_BY   = 3;
    localparam int unsigned DO_A_F1 = 4;
    localparam int unsigned DO_A_F2 = 5;
    localparam int unsigned DO_B_F1 = 6;
    localparam int unsigned DO_B_F2 = 7;

    localparam logic [POS_W-1:0] CENTER_POS = 8'd128;

    // Unsigned 0..255 stick position; digital pads snap to the ends or the centre.
    function automatic logic [POS_W-1:0] axis_pos(
        input logic             dir_lo,
        input logic             dir_hi,
        input logic [POS_W-1:0] analog,
        input logic             analog_mode
    );
        logic [POS_W-1:0] pos;
        pos = CENTER_POS;
        if (analog_mode) begin
            pos = {~analog[POS_W-1], analog[POS_W-2:0]};
        end else if (dir_lo && !dir_hi) begin
            pos = '0;
        end else if (dir_hi && !dir_lo) begin
            pos = '1;
        end
        return pos;
    endfunction

endpackage

// File: rtl/gameport_axis_timer.sv
// One 558 timer channel: loads a unit count on trigger and counts down on ticks.
module gameport_axis_timer #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] target,
    input  logic             tick,
    output logic             axis
);

    logic [CNT_W-1:0] count;

    // axis tracks (count != 0) as a register so it can feed the read byte and busy directly.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            axis  <= 1'b0;
        end else if (load) begin
            count <= target;
            axis  <= (target != '0);
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
            axis  <= (count != CNT_W'(1));
        end
    end

endmodule

// File: rtl/pc_gameport.sv
// Port 0x201 game-port emulator: shared unit prescaler, per-axis timers and read-back byte.
module pc_gameport
    import gameport_pkg::*;
#(
    parameter int unsigned NUM_JOY      = 2,
    parameter int unsigned CYC_PER_UNIT = 31,
    parameter int unsigned BASE_UNITS   = 24,
    parameter int unsigned CNT_W        = 10
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    port_cs,
    input  logic                    port_wr,
    input  logic                    port_rd,
    output logic [7:0]              port_dout,
    input  logic [NUM_JOY*JD_W-1:0] joy_digital,
    input  logic [NUM_JOY*JA_W-1:0] joy_analog,
    input  logic [NUM_JOY-1:0]      analog_en,
    output logic [NUM_JOY*2-1:0]    busy
);

    localparam int unsigned NUM_AXES = NUM_JOY * 2;
    localparam int unsigned PRE_W    = (CYC_PER_UNIT > 1) ? $clog2(CYC_PER_UNIT) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_PER_UNIT - 1);

    logic                trigger;
    logic                rd_hit;
    logic                any_active;
    logic                tick;
    logic [PRE_W-1:0]    prescaler;
    logic [NUM_AXES-1:0] axis_bits;
    logic [1:0]          axis_pair [2];
    logic [1:0]          fire_pair [2];
    logic [7:0]          rd_byte;

    assign trigger    = port_cs & port_wr;
    assign rd_hit     = port_cs & port_rd;
    assign any_active = |axis_bits;
    assign tick       = any_active && (prescaler == PRE_LAST);
    assign busy       = axis_bits;

    // Prescaler idles once every axis has expired; a trigger restarts the unit phase.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (trigger) begin
            prescaler <= '0;
        end else if (any_active) begin
            prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_W'(1);
        end
    end

    for (genvar j = 0; j < 2; j++) begin : g_joy
        if (j < NUM_JOY) begin : g_present
            logic [POS_W-1:0] pos_x;
            logic [POS_W-1:0] pos_y;
            logic [CNT_W-1:0] target_x;
            logic [CNT_W-1:0] target_y;

            assign pos_x = axis_pos(joy_digital[j*JD_W + JD_LEFT],
                                    joy_digital[j*JD_W + JD_RIGHT],
                                    joy_analog[j*JA_W +: POS_W],
                                    analog_en[j]);
            assign pos_y = axis_pos(joy_digital[j*JD_W + JD_UP],
                                    joy_digital[j*JD_W + JD_DOWN],
                                    joy_analog[j*JA_W + POS_W +: POS_W],
                                    analog_en[j]);
            assign target_x = CNT_W'(BASE_UNITS) + CNT_W'(pos_x);
            assign target_y = CNT_W'(BASE_UNITS) + CNT_W'(pos_y);

            gameport_axis_timer #(.CNT_W(CNT_W)) u_x (
                .clk_sys (clk_sys),
                .reset_n (reset_n),
                .load    (trigger),
                .target  (target_x),
                .tick    (tick),
                .axis    (axis_bits[2*j])
            );

            gameport_axis_timer #(.CNT_W(CNT_W)) u_y (
                .clk_sys (clk_sys),
                .reset_n (reset_n),
                .load    (trigger),
                .target  (target_y),
                .tick    (tick),
                .axis    (axis_bits[2*j+1])
            );

            assign axis_pair[j] = {axis_bits[2*j+1], axis_bits[2*j]};
            assign fire_pair[j] = {~joy_digital[j*JD_W + JD_FIRE2],
                                   ~joy_digital[j*JD_W + JD_FIRE1]};
        end else begin : g_absent
            // An unplugged stick looks like a timer that never expires and idle buttons.
            assign axis_pair[j] = 2'b11;
            assign fire_pair[j] = 2'b11;
        end
    end

    always_comb begin
        rd_byte = '1;
        rd_byte[DO_AX]   = axis_pair[0][0];
        rd_byte[DO_AY]   = axis_pair[0][1];
        rd_byte[DO_BX]   = axis_pair[1][0];
        rd_byte[DO_BY]   = axis_pair[1][1];
        rd_byte[DO_A_F1] = fire_pair[0][0];
        rd_byte[DO_A_F2] = fire_pair[0][1];
        rd_byte[DO_B_F1] = fire_pair[1][0];
        rd_byte[DO_B_F2] = fire_pair[1][1];
    end

    // Axis bits come from the timer registers, so a same-cycle write is not yet visible.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            port_dout <= 8'h00;
        end else if (rd_hit) begin
            port_dout <= rd_byte;
        end
    end

endmodule

// File: tb/tb_pc_gameport.sv
// Directed bench for pc_gameport: two-stick build plus a single-stick build.
module tb_pc_gameport;

    logic        clk_sys;
    logic        reset_n;

    logic        port_cs, port_wr, port_rd;
    logic [7:0]  port_dout;
    logic [15:0] joy_digital;
    logic [31:0] joy_analog;
    logic [1:0]  analog_en;
    logic [3:0]  busy;

    logic        cs1, wr1, rd1;
    logic [7:0]  dout1;
    logic [7:0]  joy_digital1;
    logic [15:0] joy_analog1;
    logic [0:0]  analog_en1;
    logic [1:0]  busy1;

    int checks = 0;
    int errors = 0;
    int len [4];

    pc_gameport dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .port_cs     (port_cs),
        .port_wr     (port_wr),
        .port_rd     (port_rd),
        .port_dout   (port_dout),
        .joy_digital (joy_digital),
        .joy_analog  (joy_analog),
        .analog_en   (analog_en),
        .busy        (busy)
    );

    pc_gameport #(.NUM_JOY(1)) dut1 (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .port_cs     (cs1),
        .port_wr     (wr1),
        .port_rd     (rd1),
        .port_dout   (dout1),
        .joy_digital (joy_digital1),
        .joy_analog  (joy_analog1),
        .analog_en   (analog_en1),
        .busy        (busy1)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One-cycle port access on either DUT; returns just after the active edge.
    task automatic port_access(input bit which, input bit do_wr, input bit do_rd);
        @(negedge clk_sys);
        if (which) begin
            cs1 = 1'b1; wr1 = do_wr; rd1 = do_rd;
        end else begin
            port_cs = 1'b1; port_wr = do_wr; port_rd = do_rd;
        end
        @(posedge clk_sys);
        #1;
        port_cs = 1'b0; port_wr = 1'b0; port_rd = 1'b0;
        cs1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic do_read(input bit which);
        port_access(which, 1'b0, 1'b1);
        @(negedge clk_sys);
    endtask

    task automatic measure_pulses(input int bound);
        bit done [4];
        for (int i = 0; i < 4; i++) begin
            len[i] = 0;
            done[i] = 1'b0;
        end
        for (int c = 0; c < bound; c++) begin
            @(negedge clk_sys);
            for (int i = 0; i < 4; i++) begin
                if (!done[i]) begin
                    if (busy[i]) len[i]++;
                    else done[i] = 1'b1;
                end
            end
            if (done[0] && done[1] && done[2] && done[3]) break;
        end
    endtask

    task automatic test_reset;
        @(negedge clk_sys);
        checks++; if (port_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", port_dout); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
        checks++; if (dout1 !== 8'h00) begin errors++; $display("FAIL reset_dout1: got %h want 00", dout1); end
        checks++; if (busy1 !== 2'b00) begin errors++; $display("FAIL reset_busy1: got %b want 00", busy1); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++; if (port_dout !== 8'h00) begin errors++; $display("FAIL post_reset_dout: got %h want 00", port_dout); end
        do_read(1'b0);
        checks++; if (port_dout !== 8'hF0) begin errors++; $display("FAIL idle_read: got %h want F0", port_dout); end
    endtask

    task automatic test_analog_centre;
        analog_en = 2'b11;
        joy_analog = 32'h0;
        port_access(1'b0, 1'b1, 1'b0);
        measure_pulses(6000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (len[i] !== 4712) begin errors++; $display("FAIL centre_len%0d: got %0d want 4712", i, len[i]); end
        end
        port_access(1'b0, 1'b1, 1'b0);
        do_read(1'b0);
        checks++; if (port_dout !== 8'hFF) begin errors++; $display("FAIL centre_read_active: got %h want FF", port_dout); end
        repeat (4800) @(negedge clk_sys);
        do_read(1'b0);
        checks++; if (port_dout !== 8'hF0) begin errors++; $display("FAIL centre_read_expired: got %h want F0", port_dout); end
    endtask

    task automatic test_digital;
        int exp_a [4];
        int exp_b [4];
        exp_a = '{744, 8649, 4712, 4712};
        exp_b = '{8649, 4712, 8649, 744};
        analog_en = 2'b00;
        joy_digital = 16'h0006;
        port_access(1'b0, 1'b1, 1'b0);
        measure_pulses(10000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (len[i] !== exp_a[i]) begin errors++; $display("FAIL digital_len%0d: got %0d want %0d", i, len[i], exp_a[i]); end
        end
        // A: right with up+down together; B: analog X=+127, Y=-128.
        analog_en = 2'b10;
        joy_digital = 16'h000B;
        joy_analog = 32'h807F_0000;
        port_access(1'b0, 1'b1, 1'b0);
        measure_pulses(10000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (len[i] !== exp_b[i]) begin errors++; $display("FAIL mixed_len%0d: got %0d want %0d", i, len[i], exp_b[i]); end
        end
        joy_digital = 16'h0;
        joy_analog = 32'h0;
    endtask

    task automatic test_input_change;
        analog_en = 2'b11;
        joy_analog = 32'h0;
        port_access(1'b0, 1'b1, 1'b0);
        joy_analog = 32'h7F7F_7F7F;
        measure_pulses(10000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (len[i] !== 4712) begin errors++; $display("FAIL hold_len%0d: got %0d want 4712", i, len[i]); end
        end
        joy_analog = 32'h0;
    endtask

    task automatic test_buttons;
        joy_digital = 16'h2010;
        do_read(1'b0);
        checks++; if (port_dout !== 8'h60) begin errors++; $display("FAIL buttons: got %h want 60", port_dout); end
        do_read(1'b0);
        checks++; if (port_dout !== 8'h60) begin errors++; $display("FAIL reread: got %h want 60", port_dout); end
        joy_digital = 16'h0;
    endtask

    task automatic test_retrigger;
        int dropped;
        analog_en = 2'b11;
        joy_analog = 32'h0;
        dropped = 0;
        port_access(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_sys);
            if (busy !== 4'hF) dropped++;
        end
        joy_analog = 32'h7F7F_7F7F;
        port_access(1'b0, 1'b1, 1'b0);
        measure_pulses(10000);
        checks++; if (dropped !== 0) begin errors++; $display("FAIL retrig_gap: got %0d low cycles want 0", dropped); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (len[i] !== 8649) begin errors++; $display("FAIL retrig_len%0d: got %0d want 8649", i, len[i]); end
        end
        joy_analog = 32'h0;
    endtask

    task automatic test_same_cycle;
        port_access(1'b0, 1'b1, 1'b1);
        @(negedge clk_sys);
        checks++; if (port_dout !== 8'hF0) begin errors++; $display("FAIL wr_rd_dout: got %h want F0", port_dout); end
        checks++; if (busy !== 4'hF) begin errors++; $display("FAIL wr_rd_busy: got %h want F", busy); end
        do_read(1'b0);
        checks++; if (port_dout !== 8'hFF) begin errors++; $display("FAIL wr_rd_next: got %h want FF", port_dout); end
    endtask

    task automatic test_reset_mid;
        repeat (100) @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL midreset_busy: got %h want 0", busy); end
        checks++; if (port_dout !== 8'h00) begin errors++; $display("FAIL midreset_dout: got %h want 00", port_dout); end
        @(negedge clk_sys);
        reset_n = 1'b1;
        do_read(1'b0);
        checks++; if (port_dout !== 8'hF0) begin errors++; $display("FAIL midreset_read: got %h want F0", port_dout); end
    endtask

    task automatic test_single_joy;
        analog_en1 = 1'b0;
        joy_digital1 = 8'h00;
        port_access(1'b1, 1'b1, 1'b0);
        do_read(1'b1);
        checks++; if (dout1 !== 8'hFF) begin errors++; $display("FAIL one_joy_active: got %h want FF", dout1); end
        repeat (20000) @(negedge clk_sys);
        do_read(1'b1);
        checks++; if (dout1 !== 8'hFC) begin errors++; $display("FAIL one_joy_expired: got %h want FC", dout1); end
        checks++; if (busy1 !== 2'b00) begin errors++; $display("FAIL one_joy_busy: got %b want 00", busy1); end
    endtask

    initial begin
        reset_n = 1'b0;
        port_cs = 1'b0; port_wr = 1'b0; port_rd = 1'b0;
        cs1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
        joy_digital = '0; joy_analog = '0; analog_en = '0;
        joy_digital1 = '0; joy_analog1 = '0; analog_en1 = '0;
        repeat (3) @(negedge clk_sys);

        test_reset;
        test_analog_centre;
        test_digital;
        test_input_change;
        test_buttons;
        test_retrigger;
        test_same_cycle;
        test_reset_mid;
        test_single_joy;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
